// File: rtl/outport_uart_tx_pkg.sv
// Shared definitions for the out-port UART transmitter: FSM encoding and
// the default baud divisor for a 50 MHz clock at 115200 baud.
package outport_uart_tx_pkg;

  localparam int CLKS_PER_BIT_115200 = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/outport_uart_tx_if.sv
// CPU-side out-port bus: write strobe and word in, status flags back.
interface outport_uart_tx_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  out_wr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  busy;
  logic                  full;
  logic                  overflow;

  modport master (output out_wr, output out_data, input busy, input full, input overflow);
  modport slave  (input out_wr, input out_data, output busy, output full, output overflow);
endinterface

// File: rtl/outport_uart_tx_sync_fifo.sv
// Small synchronous FIFO with registered full/empty/count flags.
// Writes while full are dropped unless a pop frees the slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic             full_reg, empty_reg;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty_reg;
  assign do_push = push && (!full_reg || do_pop);

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
      full_reg  <= (count_next == FULL_COUNT);
      empty_reg <= (count_next == '0);
    end
  end

  // Storage is not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Fall-through read so a word pushed one edge earlier can be popped now.
  assign dout  = mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;
  assign count = count_reg;

endmodule

// File: rtl/outport_uart_tx.sv
// Out-port UART transmitter: buffers CPU out-port words and sends each as
// four 8N1 bytes, least-significant byte first.
module outport_uart_tx
  import outport_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_WIDTH   = 32
) (
  input  logic             clk,
  input  logic             clr,
  outport_uart_tx_if.slave bus,
  output logic             tx
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  tx_state_e             state_reg, state_next;
  logic [BAUD_W-1:0]     baud_reg, baud_next;
  logic [2:0]            bit_idx_reg, bit_idx_next;
  logic [1:0]            byte_idx_reg, byte_idx_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, overflow_reg;

  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [CNT_W-1:0]      fifo_count;
  logic                  baud_done;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (bus.out_wr),
    .pop   (fifo_pop),
    .din   (bus.out_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_done = (baud_reg == BAUD_LAST);

  always_comb begin
    state_next    = state_reg;
    baud_next     = baud_reg;
    bit_idx_next  = bit_idx_reg;
    byte_idx_next = byte_idx_reg;
    shift_next    = shift_reg;
    tx_next       = 1'b1;
    fifo_pop      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          shift_next    = fifo_dout;
          byte_idx_next = 2'd0;
          baud_next     = '0;
          state_next    = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_done) begin
          baud_next    = '0;
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      DATA: begin
        tx_next = shift_reg[bit_idx_reg];
        if (baud_done) begin
          baud_next = '0;
          if (bit_idx_reg == 3'd7) state_next = STOP;
          else                     bit_idx_next = bit_idx_reg + 3'd1;
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          // Next byte starts straight after the stop bit; only words get an idle gap.
          if (byte_idx_reg != 2'd3) begin
            byte_idx_next = byte_idx_reg + 2'd1;
            shift_next    = {8'h00, shift_reg[DATA_WIDTH-1:8]};
            state_next    = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg    <= IDLE;
      baud_reg     <= '0;
      bit_idx_reg  <= 3'd0;
      byte_idx_reg <= 2'd0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_reg     <= baud_next;
      bit_idx_reg  <= bit_idx_next;
      byte_idx_reg <= byte_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      busy_reg     <= (state_reg != IDLE) || (fifo_count != '0);
      overflow_reg <= overflow_reg | (bus.out_wr & fifo_full & ~fifo_pop);
    end
  end

  assign tx           = tx_reg;
  assign bus.busy     = busy_reg;
  assign bus.full     = fifo_full;
  assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_outport_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a UART decoder on tx
// pops and compares them. Instance A runs at 4 clocks/bit, B at 2.
module tb_outport_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_a, clr_b;
  logic tx_a, tx_b;
  outport_uart_tx_if #(.DATA_WIDTH(32)) bus_a ();
  outport_uart_tx_if #(.DATA_WIDTH(32)) bus_b ();

  outport_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .DATA_WIDTH(32)) dut_a (
    .clk(clk), .clr(clr_a), .bus(bus_a), .tx(tx_a));
  outport_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4), .DATA_WIDTH(32)) dut_b (
    .clk(clk), .clr(clr_b), .bus(bus_b), .tx(tx_b));

  typedef struct {
    logic [7:0] b;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic sel;
  logic tx_mon, busy_mon, full_mon, ovf_mon;
  assign tx_mon   = sel ? tx_b : tx_a;
  assign busy_mon = sel ? bus_b.busy : bus_a.busy;
  assign full_mon = sel ? bus_b.full : bus_a.full;
  assign ovf_mon  = sel ? bus_b.overflow : bus_a.overflow;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  // gap: required distance from the previous start bit (0 = unchecked)
  task automatic push_word(input logic [31:0] w, input bit b2b, input int cpb);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.b   = w[8*i +: 8];
      e.gap = (i == 0) ? (b2b ? 10*cpb + 1 : 0) : 10*cpb;
      exp_q.push_back(e);
    end
  endtask

  task automatic set_wr(input logic v, input logic [31:0] d);
    if (sel) begin
      bus_b.out_wr = v; bus_b.out_data = d;
    end else begin
      bus_a.out_wr = v; bus_a.out_data = d;
    end
  endtask

  // UART decoder: samples mid-bit on the falling clock edge.
  bit         mon_active = 1'b0;
  int         mon_cnt    = 0;
  int         mon_start  = 0;
  int         mon_last   = 0;
  logic [9:0] mon_bits   = '0;

  always @(negedge clk) begin
    int   cpb;
    exp_t e;
    cpb = sel ? 2 : 4;
    if (!mon_active) begin
      if (tx_mon === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_start  = cyc;
      end
    end else begin
      mon_cnt++;
    end
    if (mon_active && (mon_cnt % cpb) == cpb/2) begin
      mon_bits = {tx_mon, mon_bits[9:1]};
      if (mon_cnt / cpb == 9) begin
        mon_active = 1'b0;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_byte got=%02h", mon_bits[8:1]);
        end else begin
          e = exp_q.pop_front();
          if (mon_bits[8:1] !== e.b || mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) begin
            bad++;
            $display("FAIL byte got=%02h start=%b stop=%b want=%02h", mon_bits[8:1], mon_bits[0], mon_bits[9], e.b);
          end else begin
            $display("byte %02h ok at cycle %0d", e.b, mon_start);
          end
          if (e.gap != 0) begin
            total++;
            if (mon_start - mon_last != e.gap) begin
              bad++;
              $display("FAIL byte_spacing got=%0d want=%0d", mon_start - mon_last, e.gap);
            end
          end
        end
        mon_last = mon_start;
      end
    end
  end

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active || busy_mon) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", 32'(exp_q.size() != 0 || mon_active || busy_mon), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    bus_a.out_wr = 1'b0; bus_a.out_data = '0;
    bus_b.out_wr = 1'b0; bus_b.out_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_a", 32'({tx_a, bus_a.busy, bus_a.full, bus_a.overflow}), 32'h8);
    chk("reset_b", 32'({tx_b, bus_b.busy, bus_b.full, bus_b.overflow}), 32'h8);
    clr_a = 1'b1; clr_b = 1'b1;

    // idle after reset: tx high, all flags low
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_outputs", 32'({tx_mon, busy_mon, full_mon, ovf_mon}), 32'h8);
    end

    // single word, start bit exactly two edges after the strobe
    @(negedge clk); set_wr(1'b1, 32'hAAAA_AAAA); push_word(32'hAAAA_AAAA, 1'b0, 4);
    @(negedge clk); set_wr(1'b0, 32'h0);
    chk("latency_edge0", 32'(tx_mon), 32'd1);
    @(negedge clk); chk("latency_edge1", 32'(tx_mon), 32'd1);
    @(negedge clk); chk("latency_edge2", 32'(tx_mon), 32'd0);
    drain(400);
    chk("busy_after_word", 32'(busy_mon), 32'd0);

    // byte order
    @(negedge clk); set_wr(1'b1, 32'h0000_00FF); push_word(32'h0000_00FF, 1'b0, 4);
    @(negedge clk); set_wr(1'b0, 32'h0);
    drain(400);

    // five writes fill the FIFO, the sixth is dropped
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 6) begin
        chk("full_before_6th", 32'(full_mon), 32'd1);
        chk("ovf_before_6th", 32'(ovf_mon), 32'd0);
      end
      set_wr(1'b1, 32'(i));
      if (i <= 5) push_word(32'(i), i > 1, 4);
    end
    @(negedge clk); set_wr(1'b0, 32'h0);
    chk("full_after_6th", 32'(full_mon), 32'd1);
    chk("ovf_after_6th", 32'(ovf_mon), 32'd1);
    drain(1200);
    chk("ovf_sticky", 32'(ovf_mon), 32'd1);
    chk("full_drained", 32'(full_mon), 32'd0);

    // reset mid-frame aborts at once
    @(negedge clk); set_wr(1'b1, 32'h1234_5678); push_word(32'h1234_5678, 1'b0, 4);
    @(negedge clk); set_wr(1'b0, 32'h0);
    repeat (12) @(negedge clk);
    chk("mid_frame_busy", 32'(busy_mon), 32'd1);
    clr_a = 1'b0;
    #1;
    exp_q.delete();
    mon_active = 1'b0;
    chk("abort_outputs", 32'({tx_mon, busy_mon, full_mon, ovf_mon}), 32'h8);
    @(negedge clk); clr_a = 1'b1;
    chk("abort_tx_high", 32'(tx_mon), 32'd1);
    @(negedge clk); set_wr(1'b1, 32'h0); push_word(32'h0, 1'b0, 4);
    @(negedge clk); set_wr(1'b0, 32'h0);
    drain(400);

    // instance B: push accepted on the pop edge while full
    sel = 1'b1;
    repeat (4) @(negedge clk);
    @(negedge clk); set_wr(1'b1, 32'h1122_3344); push_word(32'h1122_3344, 1'b0, 2);
    @(negedge clk); set_wr(1'b1, 32'h5566_7788); push_word(32'h5566_7788, 1'b1, 2);
    @(negedge clk); set_wr(1'b1, 32'h99AA_BBCC); push_word(32'h99AA_BBCC, 1'b1, 2);
    @(negedge clk); set_wr(1'b1, 32'hDDEE_FF00); push_word(32'hDDEE_FF00, 1'b1, 2);
    @(negedge clk); set_wr(1'b1, 32'h0F1E_2D3C); push_word(32'h0F1E_2D3C, 1'b1, 2);
    @(negedge clk); set_wr(1'b0, 32'h0);
    repeat (76) @(negedge clk);
    chk("b_full_before_pop", 32'(full_mon), 32'd1);
    @(negedge clk); set_wr(1'b1, 32'hC3D2_E1F0); push_word(32'hC3D2_E1F0, 1'b1, 2);
    @(negedge clk); set_wr(1'b0, 32'h0);
    chk("b_full_after_pop", 32'(full_mon), 32'd1);
    chk("b_no_overflow", 32'(ovf_mon), 32'd0);
    drain(700);
    chk("b_ovf_final", 32'(ovf_mon), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/outport_uart_tx.md
Name: outport_uart_tx

Overview:
Downstream consumer of the CPU datapath's 32-bit output port (OutportOut of ControlUnitBus). It captures each word the CPU writes to the out-port into a small FIFO. It then serialises each word over a UART TX line as 4 bytes, LSB byte first, in 8N1 framing. This lets a bench or board observe program output without probing internal registers.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥2.
FIFO_DEPTH, 4, words buffered; power of two, ≥2.
DATA_WIDTH, 32, out-port word width; fixed at 32 (4 bytes).

Ports:
clk  in  1  system clock, rising-edge.
clr  in  1  asynchronous, active-low reset.
out_wr  in  1  one-cycle strobe: CPU wrote the out-port this cycle.
out_data  in  32  out-port word (OutportOut), sampled when out_wr=1.
tx  out  1  UART serial line, idle high.
busy  out  1  high while a word is being serialised or the FIFO is non-empty.
full  out  1  FIFO holds FIFO_DEPTH words.
overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset (clr=0, async): FIFO empty, pointers 0, state IDLE, tx=1, busy=0, full=0, overflow=0. Reset mid-frame aborts immediately; tx returns to 1 with no stop bit.
- All outputs registered.
- Push: out_wr=1 and not full at the rising edge → word written; count+1.
- Push while full → word discarded; overflow←1 until reset.
- Pop occurs in IDLE when count>0: head word loaded into shift reg, byte index←0, count−1.
- Push and pop on the same edge → count unchanged; the push is accepted even when full.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. On pop → START.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA, bit index 0.
  - DATA: tx=current byte bit[bit index], LSB first, each for CLKS_PER_BIT cycles. After bit 7 → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte index<3: byte index+1, → START, with no idle gap. Else → IDLE.
- Baud counter: counts 0..CLKS_PER_BIT−1 and reloads 0 on every state/bit change.
- Byte order: out_data[7:0], [15:8], [23:16], [31:24].
- Latency: out_wr at edge N (FIFO empty, IDLE) → pop at edge N+1 → tx=0 from edge N+2.
- Frame length: 40·CLKS_PER_BIT cycles per word; back-to-back words have exactly one IDLE cycle between frames.
- busy = (state≠IDLE) or (count>0).
- No backpressure to the CPU; software must respect the full flag.

Decomposition:
- Shared package: FSM state encoding (2-bit localparams IDLE=0, START=1, DATA=2, STOP=3) and the default baud constant CLKS_PER_BIT_115200=434.
- One sub-module, sync_fifo:
  - parameterised width/depth; push, pop, din, dout, full, empty, count.
  - same clk/clr convention.
  - drop-on-full is handled in sync_fifo; the overflow flag lives in the top.

Test Plan (CLKS_PER_BIT=4 unless noted):
1. Reset then idle 50 cycles → tx=1, busy=0, full=0, overflow=0 throughout.
2. Single out_wr with 0xAAAAAAAA → tx=0 two edges after the strobe. Each byte is 0,0,1,0,1,0,1,0,1,1 (start, LSB-first data, stop), 4 cycles per bit, 160 cycles total. Afterwards busy=0.
3. Write 0x000000FF → first byte data bits all 1, remaining three bytes all 0; byte order verified LSB first.
4. Five back-to-back writes 0x1..0x5 in consecutive cycles → full=1 after the fourth is stored (first already popped, so none dropped). Sixth write while full → dropped, overflow=1. Serialised order is 1,2,3,4,5.
5. Pulse clr low for 1 cycle mid-DATA of 0x12345678 → tx=1 immediately, FIFO empty, overflow=0. Next write 0x0 transmits cleanly.
6. CLKS_PER_BIT=2: push on the same edge as a pop with the FIFO full → count stays 4, no overflow, all words transmitted in order.
